// File: rtl/mem_access_stage_pkg.sv
// mem_access_stage_pkg: FSM states, load funct3 codes, AXI response code and misalignment helper
package mem_access_stage_pkg;
  typedef enum logic [2:0] {IDLE, RD, RWAIT, WR, BWAIT, DONE} state_t;
  localparam logic [2:0] MR_LB  = 3'b000;
  localparam logic [2:0] MR_LH  = 3'b001;
  localparam logic [2:0] MR_LW  = 3'b010;
  localparam logic [2:0] MR_LBU = 3'b100;
  localparam logic [2:0] MR_LHU = 3'b101;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  // Stores are sized by their byte mask, loads by funct3.
  function automatic logic lsu_misaligned(input logic wen, input logic [2:0] mrtype,
                                          input logic [3:0] wmask, input logic [1:0] off);
    logic half, word;
    half = wen ? (wmask == 4'b0011) : (mrtype == MR_LH || mrtype == MR_LHU);
    word = wen ? (wmask == 4'b1111) : (mrtype == MR_LW);
    return (half && off[0]) || (word && off != 2'b00);
  endfunction
endpackage

// File: rtl/mem_access_stage_align.sv
// lsu_load_align: shift a bus word down to the addressed byte and sign/zero-extend per funct3
// Ports: rdata (raw bus word), off (address bits [1:0]), mrtype (load funct3), data (extended result)
module lsu_load_align
  import mem_access_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  mrtype,
  output logic [31:0] data
);
  logic [31:0] s;
  always_comb begin
    s = rdata >> {off, 3'b000};
    data = mrtype == MR_LB  ? {{24{s[7]}}, s[7:0]} :
           mrtype == MR_LH  ? {{16{s[15]}}, s[15:0]} :
           mrtype == MR_LBU ? {24'h0, s[7:0]} :
           mrtype == MR_LHU ? {16'h0, s[15:0]} : s;
  end
endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: M-stage load/store unit issuing AXI4-Lite accesses and registering results for W
// Ports: clk, rst (async active-low); s_valid/s_ready upstream; *M instruction fields in;
//   AXI-Lite AR/R/AW/W/B master channels; m_valid/m_ready downstream; *W registered fields out,
//   rdataW (extended load data), buserrW (non-OKAY response), misalignW (misalignment trap).
// Optional: LSU_MISALIGN_TRAP_EN turns misaligned lh/lhu/lw/sh/sw into a bus-less trap; otherwise misalignW stays 0.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic          mvalidM,
  input  logic          mwenM,
  input  logic [7:0]    mwmaskM,
  input  logic [2:0]    mrtypeM,
  input  logic [31:0]   ALU_resultM,
  input  logic [31:0]   src2M,
  input  logic [1:0]    rdregsrcM,
  input  logic [4:0]    rdM,
  input  logic [31:0]   pcM,
  input  logic [31:0]   dnpcM,
  input  logic [11:0]   csraddrM,
  input  logic          csrM,
  input  logic          ecallM,
  output logic [AW-1:0] araddr,
  output logic          arvalid,
  input  logic          arready,
  input  logic [DW-1:0] rdata,
  input  logic [1:0]    rresp,
  input  logic          rvalid,
  output logic          rready,
  output logic [AW-1:0] awaddr,
  output logic          awvalid,
  input  logic          awready,
  output logic [DW-1:0] wdata,
  output logic [DW/8-1:0] wstrb,
  output logic          wvalid,
  input  logic          wready,
  input  logic [1:0]    bresp,
  input  logic          bvalid,
  output logic          bready,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [31:0]   rdataW,
  output logic [1:0]    rdregsrcW,
  output logic [4:0]    rdW,
  output logic [31:0]   pcW,
  output logic [31:0]   dnpcW,
  output logic [11:0]   csraddrW,
  output logic          csrW,
  output logic          ecallW,
  output logic          buserrW,
  output logic          misalignW
);
  state_t state, nxt;
  logic [AW-1:0] addr_q;
  logic [3:0]  wmask_q;
  logic [31:0] src2_q, load_data;
  logic [2:0]  mrtype_q;
  logic aw_done, w_done, accept, mis_in;
  logic unused_mask_hi;
  assign unused_mask_hi = ^mwmaskM[7:4];
`ifdef LSU_MISALIGN_TRAP_EN
  assign mis_in = mvalidM && lsu_misaligned(mwenM, mrtypeM, mwmaskM[3:0], ALU_resultM[1:0]);
`else
  assign mis_in = 1'b0;
`endif
  lsu_load_align u_align (
    .rdata (rdata),
    .off   (addr_q[1:0]),
    .mrtype(mrtype_q),
    .data  (load_data)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else state <= nxt;
  end
  // Bus valids are pure decodes of state so an asserted reset drops them without a clock.
  always_comb begin
    nxt     = state;
    s_ready = state == IDLE;
    accept  = s_valid && s_ready;
    arvalid = state == RD;
    rready  = state == RWAIT;
    awvalid = state == WR && !aw_done;
    wvalid  = state == WR && !w_done;
    bready  = state == BWAIT;
    m_valid = state == DONE;
    araddr  = {addr_q[AW-1:2], 2'b00};
    awaddr  = {addr_q[AW-1:2], 2'b00};
    wdata   = src2_q << {addr_q[1:0], 3'b000};
    wstrb   = wmask_q << addr_q[1:0];
    case (state)
      IDLE:    nxt = !accept ? IDLE : (mis_in || !mvalidM) ? DONE : mwenM ? WR : RD;
      RD:      nxt = arready ? RWAIT : RD;
      RWAIT:   nxt = rvalid ? DONE : RWAIT;
      WR:      nxt = ((aw_done || awready) && (w_done || wready)) ? BWAIT : WR;
      BWAIT:   nxt = bvalid ? DONE : BWAIT;
      DONE:    nxt = m_ready ? IDLE : DONE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q    <= '0;
      wmask_q   <= '0;
      src2_q    <= '0;
      mrtype_q  <= '0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      rdataW    <= '0;
      rdregsrcW <= '0;
      rdW       <= '0;
      pcW       <= '0;
      dnpcW     <= '0;
      csraddrW  <= '0;
      csrW      <= 1'b0;
      ecallW    <= 1'b0;
      buserrW   <= 1'b0;
      misalignW <= 1'b0;
    end else begin
      if (accept) begin
        addr_q    <= ALU_resultM[AW-1:0];
        wmask_q   <= mwmaskM[3:0];
        src2_q    <= src2M;
        mrtype_q  <= mrtypeM;
        aw_done   <= 1'b0;
        w_done    <= 1'b0;
        rdataW    <= '0;
        rdregsrcW <= rdregsrcM;
        rdW       <= rdM;
        pcW       <= pcM;
        dnpcW     <= dnpcM;
        csraddrW  <= csraddrM;
        csrW      <= csrM;
        ecallW    <= ecallM;
        buserrW   <= 1'b0;
        misalignW <= mis_in;
      end
      if (awvalid && awready) aw_done <= 1'b1;
      if (wvalid && wready) w_done <= 1'b1;
      if (rready && rvalid) begin
        rdataW  <= load_data;
        buserrW <= rresp != RESP_OKAY;
      end
      if (bready && bvalid) buserrW <= bresp != RESP_OKAY;
    end
  end
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed-vector bench for mem_access_stage with a scripted AXI-Lite slave
module tb_mem_access_stage;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, s_valid, s_ready, mvalidM, mwenM;
  logic [7:0] mwmaskM;
  logic [2:0] mrtypeM;
  logic [31:0] ALU_resultM, src2M, pcM, dnpcM;
  logic [1:0] rdregsrcM;
  logic [4:0] rdM;
  logic [11:0] csraddrM;
  logic csrM, ecallM;
  logic [31:0] araddr, awaddr, rdata, wdata;
  logic arvalid, arready, rvalid, rready, awvalid, awready, wvalid, wready, bvalid, bready;
  logic [1:0] rresp, bresp;
  logic [3:0] wstrb;
  logic m_valid, m_ready;
  logic [31:0] rdataW, pcW, dnpcW;
  logic [1:0] rdregsrcW;
  logic [4:0] rdW;
  logic [11:0] csraddrW;
  logic csrW, ecallW, buserrW, misalignW;
  int checks = 0, errors = 0;

  mem_access_stage dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
    .mvalidM(mvalidM), .mwenM(mwenM), .mwmaskM(mwmaskM), .mrtypeM(mrtypeM),
    .ALU_resultM(ALU_resultM), .src2M(src2M), .rdregsrcM(rdregsrcM), .rdM(rdM),
    .pcM(pcM), .dnpcM(dnpcM), .csraddrM(csraddrM), .csrM(csrM), .ecallM(ecallM),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .m_valid(m_valid), .m_ready(m_ready),
    .rdataW(rdataW), .rdregsrcW(rdregsrcW), .rdW(rdW), .pcW(pcW), .dnpcW(dnpcW),
    .csraddrW(csraddrW), .csrW(csrW), .ecallW(ecallW), .buserrW(buserrW), .misalignW(misalignW)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic mv, input logic wen, input logic [7:0] mask,
                       input logic [2:0] t, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    check("s_ready_idle", s_ready, 1);
    mvalidM = mv; mwenM = wen; mwmaskM = mask; mrtypeM = t; ALU_resultM = a; src2M = d;
    s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic do_load(input string tag, input logic [31:0] a, input logic [2:0] t,
                         input logic [31:0] rd, input logic [1:0] rr, input int arw, input int mw,
                         input logic [31:0] exp, input logic experr);
    m_ready = (mw == 0);
    issue(1'b1, 1'b0, 8'h0F, t, a, 32'h0);
    check({tag, "_arvalid"}, arvalid, 1);
    check({tag, "_araddr"}, araddr, {a[31:2], 2'b00});
    check({tag, "_awvalid"}, awvalid, 0);
    repeat (arw) begin
      @(negedge clk);
      check({tag, "_arvalid_hold"}, arvalid, 1);
      check({tag, "_araddr_hold"}, araddr, {a[31:2], 2'b00});
      check({tag, "_s_ready_busy"}, s_ready, 0);
    end
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    check({tag, "_ar_dropped"}, arvalid, 0);
    check({tag, "_rready"}, rready, 1);
    rvalid = 1'b1; rdata = rd; rresp = rr;
    @(negedge clk);
    rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00;
    check({tag, "_m_valid"}, m_valid, 1);
    check({tag, "_rdataW"}, rdataW, exp);
    check({tag, "_buserrW"}, buserrW, experr);
    check({tag, "_misalignW"}, misalignW, 0);
    repeat (mw) begin
      @(negedge clk);
      check({tag, "_m_valid_hold"}, m_valid, 1);
      check({tag, "_rdataW_hold"}, rdataW, exp);
      check({tag, "_s_ready_done"}, s_ready, 0);
    end
    m_ready = 1'b1;
    @(negedge clk);
    check({tag, "_back_idle"}, s_ready, 1);
    check({tag, "_m_valid_low"}, m_valid, 0);
  endtask

  task automatic do_store(input string tag, input logic [31:0] a, input logic [7:0] mask,
                          input logic [31:0] d, input int lag, input logic [3:0] exp_strb,
                          input logic [31:0] exp_data, input logic [1:0] br, input logic experr);
    issue(1'b1, 1'b1, mask, 3'b000, a, d);
    check({tag, "_awvalid"}, awvalid, 1);
    check({tag, "_wvalid"}, wvalid, 1);
    check({tag, "_arvalid"}, arvalid, 0);
    check({tag, "_wstrb"}, wstrb, exp_strb);
    check({tag, "_wdata"}, wdata, exp_data);
    wready = 1'b1;
    awready = (lag == 0);
    if (lag > 0) begin
      @(negedge clk);
      wready = 1'b0;
      check({tag, "_w_dropped"}, wvalid, 0);
      check({tag, "_aw_held"}, awvalid, 1);
      repeat (lag - 1) begin
        @(negedge clk);
        check({tag, "_aw_held"}, awvalid, 1);
        check({tag, "_bready_early"}, bready, 0);
      end
      awready = 1'b1;
    end
    @(negedge clk);
    wready = 1'b0; awready = 1'b0;
    check({tag, "_aw_dropped"}, awvalid, 0);
    check({tag, "_w_dropped2"}, wvalid, 0);
    check({tag, "_bready"}, bready, 1);
    bvalid = 1'b1; bresp = br;
    @(negedge clk);
    bvalid = 1'b0; bresp = 2'b00;
    check({tag, "_m_valid"}, m_valid, 1);
    check({tag, "_buserrW"}, buserrW, experr);
    check({tag, "_rdataW"}, rdataW, 0);
    @(negedge clk);
    check({tag, "_back_idle"}, s_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; s_valid = 1'b0; mvalidM = 1'b0; mwenM = 1'b0; mwmaskM = 8'h0; mrtypeM = 3'b0;
    ALU_resultM = 32'h0; src2M = 32'h0; rdregsrcM = 2'b0; rdM = 5'd0; pcM = 32'h0; dnpcM = 32'h0;
    csraddrM = 12'h0; csrM = 1'b0; ecallM = 1'b0; arready = 1'b0; rvalid = 1'b0; rdata = 32'h0;
    rresp = 2'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b0; m_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_s_ready", s_ready, 1);
    check("rst_arvalid", arvalid, 0);
    check("rst_awvalid", awvalid, 0);
    check("rst_wvalid", wvalid, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_rdataW", rdataW, 0);
    check("rst_pcW", pcW, 0);
    check("rst_buserrW", buserrW, 0);
    check("rst_misalignW", misalignW, 0);
    rst = 1'b1;

    rdregsrcM = 2'd2; rdM = 5'd7; pcM = 32'h100; dnpcM = 32'h104; csraddrM = 12'h305;
    csrM = 1'b1; ecallM = 1'b1;
    issue(1'b0, 1'b0, 8'h00, 3'b000, 32'h8000_0010, 32'h0);
    check("alu_m_valid", m_valid, 1);
    check("alu_arvalid", arvalid, 0);
    check("alu_awvalid", awvalid, 0);
    check("alu_rdataW", rdataW, 0);
    check("alu_pcW", pcW, 32'h100);
    check("alu_dnpcW", dnpcW, 32'h104);
    check("alu_rdW", rdW, 7);
    check("alu_rdregsrcW", rdregsrcW, 2);
    check("alu_csraddrW", csraddrW, 12'h305);
    check("alu_csrW", csrW, 1);
    check("alu_ecallW", ecallW, 1);
    @(negedge clk);
    check("alu_back_idle", s_ready, 1);
    csrM = 1'b0; ecallM = 1'b0;

    do_load("lb", 32'h8000_0003, 3'b000, 32'h80FF_FFFF, 2'b00, 0, 0, 32'hFFFF_FF80, 1'b0);
    do_load("lbu", 32'h8000_0003, 3'b100, 32'h80FF_FFFF, 2'b00, 0, 0, 32'h0000_0080, 1'b0);
    do_load("lh", 32'h8000_0002, 3'b001, 32'h8001_1234, 2'b00, 0, 0, 32'hFFFF_8001, 1'b0);
    do_load("lhu", 32'h8000_0002, 3'b101, 32'h8001_1234, 2'b00, 1, 0, 32'h0000_8001, 1'b0);
    do_load("lw_stall", 32'h8000_0004, 3'b010, 32'hCAFE_F00D, 2'b00, 5, 3, 32'hCAFE_F00D, 1'b0);
    do_load("lw_slverr", 32'h8000_0008, 3'b010, 32'h1234_5678, 2'b10, 0, 0, 32'h1234_5678, 1'b1);

    do_store("sh", 32'h8000_0002, 8'h03, 32'h1234_ABCD, 3, 4'b1100, 32'hABCD_0000, 2'b00, 1'b0);
    do_store("sb", 32'h8000_0001, 8'h01, 32'h0000_00A5, 0, 4'b0010, 32'h0000_A500, 2'b00, 1'b0);
    do_store("sw_err", 32'h8000_0000, 8'h0F, 32'hDEAD_BEEF, 1, 4'b1111, 32'hDEAD_BEEF, 2'b10, 1'b1);
    issue(1'b0, 1'b0, 8'h00, 3'b000, 32'h0, 32'h0);
    check("after_err_m_valid", m_valid, 1);
    check("after_err_buserrW", buserrW, 0);
    @(negedge clk);

`ifdef LSU_MISALIGN_TRAP_EN
    issue(1'b1, 1'b0, 8'h0F, 3'b010, 32'h8000_0002, 32'h0);
    check("mis_m_valid", m_valid, 1);
    check("mis_misalignW", misalignW, 1);
    check("mis_arvalid", arvalid, 0);
    check("mis_rdataW", rdataW, 0);
    @(negedge clk);
    check("mis_back_idle", s_ready, 1);
`else
    do_load("lw_unaligned", 32'h8000_0002, 3'b010, 32'h1122_3344, 2'b00, 0, 0, 32'h0000_1122, 1'b0);
`endif

    issue(1'b1, 1'b0, 8'h0F, 3'b010, 32'h8000_0008, 32'h0);
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    check("rstmid_rready", rready, 1);
    #2 rst = 1'b0;
    #1;
    check("rstmid_rready_async", rready, 0);
    check("rstmid_arvalid_async", arvalid, 0);
    check("rstmid_awvalid_async", awvalid, 0);
    check("rstmid_m_valid_async", m_valid, 0);
    check("rstmid_s_ready_async", s_ready, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_s_ready", s_ready, 1);
    check("rstmid_rdataW", rdataW, 0);
    check("rstmid_m_valid", m_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
